// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Multiplexed N-digit 7-segment (+DP) display driver. One shared segment bus
// is time-sliced across NUM_DIGITS common-pin digit enables. Each slot starts
// with an anti-ghosting blank interval, then a brightness-controlled PWM
// window. Segment data, digit enable and brightness are snapshotted at the
// start of every slot so a digit never changes mid-slot.
//
// Ports:
//   clk        system clock
//   rstN       asynchronous active-low reset (release synchronised internally)
//   segIn      segment patterns, digit k at [k*SEG_W +: SEG_W], 1 = segment on
//   digEn      per-digit enable, 0 = digit stays dark in its slot
//   bright     global brightness, 0 = 1/16 of the window, 15 = full window
//   seg        segment drive (inverted when SEG_ACTIVE_LOW)
//   segDig     digit drive (active low when DIG_ACTIVE_LOW)
//   scanIdx    index of the digit owning the current slot
//   slotStart  one-cycle pulse on the first output cycle of each slot
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_W          = 8,
    parameter int TICK_DIV       = 1200,
    parameter int BLANK_CYC      = 16,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                                              clk,
    input  logic                                              rstN,
    input  logic [NUM_DIGITS*SEG_W-1:0]                       segIn,
    input  logic [NUM_DIGITS-1:0]                             digEn,
    input  logic [3:0]                                        bright,
    output logic [SEG_W-1:0]                                  seg,
    output logic [NUM_DIGITS-1:0]                             segDig,
    output logic [$clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2)-1:0] scanIdx,
    output logic                                              slotStart
);

    localparam int IDX_W = $clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2);
    localparam int CNT_W = $clog2(TICK_DIV);
    // n*16 and W*(br+1) both fit in CNT_W+5 bits, even when TICK_DIV is a power of 2
    localparam int CMP_W = CNT_W + 5;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CMP_W-1:0]      WIN       = CMP_W'(TICK_DIV - BLANK_CYC);
    localparam logic [SEG_W-1:0]      SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic                  rstMeta;
    logic                  rstSyncN;
    logic [CNT_W-1:0]      slotCnt;
    logic [IDX_W-1:0]      digIdx;
    logic [SEG_W-1:0]      snapshot;
    logic                  en;
    logic [3:0]            br;
    logic [SEG_W-1:0]      curSeg;
    logic                  curEn;
    logic [CMP_W-1:0]      nScaled;
    logic [CMP_W-1:0]      wScaled;
    logic                  lit;
    logic [NUM_DIGITS-1:0] digOn;

    // Reset: asserts immediately, releases two clk edges after rstN rises
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rstMeta  <= 1'b0;
            rstSyncN <= 1'b0;
        end else begin
            rstMeta  <= 1'b1;
            rstSyncN <= rstMeta;
        end
    end

    // Slot timing: slotCnt walks the slot, digIdx advances on the last cycle
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            slotCnt <= '0;
            digIdx  <= '0;
        end else if (slotCnt == CNT_LAST) begin
            slotCnt <= '0;
            digIdx  <= (digIdx == IDX_LAST) ? '0 : digIdx + 1'b1;
        end else begin
            slotCnt <= slotCnt + 1'b1;
        end
    end

    // Decoded select keeps indexing inside segIn/digEn for non-power-of-2 counts
    always_comb begin
        curSeg = '0;
        curEn  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digIdx == IDX_W'(k)) begin
                curSeg = segIn[k*SEG_W +: SEG_W];
                curEn  = digEn[k];
            end
        end
    end

    // Slot snapshot: captured once at slotCnt==0 and held for the whole slot
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            snapshot <= '0;
            en       <= 1'b0;
            br       <= '0;
        end else if (slotCnt == '0) begin
            snapshot <= curSeg;
            en       <= curEn;
            br       <= bright;
        end
    end

    // PWM window: lit while (slotCnt-BLANK)*16 < W*(br+1); the subtraction is
    // only meaningful past the blank interval, which the first term guards
    always_comb begin
        nScaled = (CMP_W'(slotCnt) - CMP_W'(BLANK_CYC)) << 4;
        wScaled = WIN * CMP_W'({1'b0, br} + 5'd1);
        lit     = (slotCnt >= CNT_BLANK) && en && (nScaled < wScaled);
    end

    always_comb begin
        digOn = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && (digIdx == IDX_W'(k))) begin
                digOn[k] = 1'b1;
            end
        end
    end

    // Output stage: every pin registered, polarity applied here
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            seg       <= SEG_OFF;
            segDig    <= DIG_OFF;
            scanIdx   <= '0;
            slotStart <= 1'b0;
        end else begin
            seg       <= (lit ? snapshot : '0) ^ SEG_OFF;
            segDig    <= digOn ^ DIG_OFF;
            scanIdx   <= digIdx;
            slotStart <= (slotCnt == '0);
        end
    end

endmodule
